// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: parametrised RAW-hazard scoreboard with forwarding select, IF/ID freeze and saturating stall counter
module hazard_scoreboard #(
  parameter int REG_W      = 5,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 3,
  parameter int NUM_SRC    = 2,
  parameter int READY_ALU  = 0,
  parameter int READY_LOAD = 1,
  parameter int CNT_W      = 16,
  localparam int SEL_W     = $clog2(DEPTH+1)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable_forward,
  input  logic [REG_W-1:0]          issue_dest,
  input  logic                      issue_wb_en,
  input  logic                      issue_mem_read,
  input  logic [NUM_SRC*REG_W-1:0]  src_addr,
  input  logic [NUM_SRC-1:0]        src_used,
  input  logic [DEPTH*DATA_W-1:0]   stage_data,
  input  logic [NUM_SRC*DATA_W-1:0] rf_data,
  input  logic                      flush,
  output logic                      stall,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic [NUM_SRC*DATA_W-1:0] fwd_data,
  output logic [DEPTH-1:0]          stage_valid,
  output logic [CNT_W-1:0]          stall_count
);
  logic [DEPTH-1:0]            valid;
  logic [DEPTH-1:0]            is_load;
  logic [DEPTH-1:0][REG_W-1:0] dest;
  logic                        raw_stall;
  logic                        found;
  logic                        m;
  assign stage_valid = valid;
  assign stall = raw_stall & ~flush;
  always_comb begin
    raw_stall = 1'b0;
    fwd_sel = '0;
    fwd_data = rf_data;
    found = 1'b0;
    m = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      found = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        m = src_used[i] && valid[k] && dest[k] == src_addr[i*REG_W +: REG_W] && src_addr[i*REG_W +: REG_W] != '0;
        if (enable_forward) begin
          if (m && !found) begin
            found = 1'b1;
            if (k >= (is_load[k] ? READY_LOAD : READY_ALU)) begin
              fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
              fwd_data[i*DATA_W +: DATA_W] = stage_data[k*DATA_W +: DATA_W];
            end else begin
              raw_stall = 1'b1;
            end
          end
        end else if (m && k < DEPTH - 1) begin
          raw_stall = 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid <= '0;
      is_load <= '0;
      dest <= '0;
      stall_count <= '0;
    end else begin
      valid <= {valid[DEPTH-2:0], ~(stall | flush) & issue_wb_en & (|issue_dest)};
      is_load <= {is_load[DEPTH-2:0], ~(stall | flush) & issue_mem_read};
      dest <= {dest[DEPTH-2:0], (stall | flush) ? {REG_W{1'b0}} : issue_dest};
      if (stall && !(&stall_count)) stall_count <= stall_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;
  logic        clock = 1'b0;
  logic        reset;
  logic        enable_forward;
  logic [4:0]  issue_dest;
  logic        issue_wb_en;
  logic        issue_mem_read;
  logic [9:0]  src_addr;
  logic [1:0]  src_used;
  logic [95:0] stage_data;
  logic [63:0] rf_data;
  logic        flush;
  logic        stall, stall2;
  logic [3:0]  fwd_sel, fwd_sel2;
  logic [63:0] fwd_data, fwd_data2;
  logic [2:0]  stage_valid, stage_valid2;
  logic [15:0] stall_count;
  logic [1:0]  stall_count2;
  int          cmp = 0;
  int          err = 0;

  hazard_scoreboard dut (
    .clock(clock), .reset(reset), .enable_forward(enable_forward), .issue_dest(issue_dest),
    .issue_wb_en(issue_wb_en), .issue_mem_read(issue_mem_read), .src_addr(src_addr),
    .src_used(src_used), .stage_data(stage_data), .rf_data(rf_data), .flush(flush),
    .stall(stall), .fwd_sel(fwd_sel), .fwd_data(fwd_data), .stage_valid(stage_valid),
    .stall_count(stall_count)
  );

  hazard_scoreboard #(.CNT_W(2)) dut2 (
    .clock(clock), .reset(reset), .enable_forward(enable_forward), .issue_dest(issue_dest),
    .issue_wb_en(issue_wb_en), .issue_mem_read(issue_mem_read), .src_addr(src_addr),
    .src_used(src_used), .stage_data(stage_data), .rf_data(rf_data), .flush(flush),
    .stall(stall2), .fwd_sel(fwd_sel2), .fwd_data(fwd_data2), .stage_valid(stage_valid2),
    .stall_count(stall_count2)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [4:0] d, input logic wb, input logic ld,
                       input logic [4:0] s1, input logic [4:0] s0, input logic [1:0] used);
    issue_dest = d;
    issue_wb_en = wb;
    issue_mem_read = ld;
    src_addr = {s1, s0};
    src_used = used;
    flush = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    issue(5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00);
    tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    cmp++; if (stall !== 1'b0) begin err++; $display("FAIL reset_stall got %0b want 0", stall); end
    cmp++; if (fwd_sel !== 4'd0) begin err++; $display("FAIL reset_fwd_sel got %h want 0", fwd_sel); end
    cmp++; if (fwd_data !== 64'h000000B1_000000B0) begin err++; $display("FAIL reset_fwd_data got %h want 000000b1000000b0", fwd_data); end
    cmp++; if (stage_valid !== 3'b000) begin err++; $display("FAIL reset_stage_valid got %b want 000", stage_valid); end
    cmp++; if (stall_count !== 16'd0) begin err++; $display("FAIL reset_stall_count got %0d want 0", stall_count); end
  endtask

  task automatic test_alu_forward();
    do_reset();
    issue(5'd3, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00);
    tick();
    issue(5'd4, 1'b1, 1'b0, 5'd0, 5'd3, 2'b01);
    cmp++; if (stall !== 1'b0) begin err++; $display("FAIL alu_stall got %0b want 0", stall); end
    cmp++; if (fwd_sel !== 4'b0001) begin err++; $display("FAIL alu_fwd_sel got %b want 0001", fwd_sel); end
    cmp++; if (fwd_data !== 64'h000000B1_000000A0) begin err++; $display("FAIL alu_fwd_data got %h want 000000b1000000a0", fwd_data); end
  endtask

  task automatic test_load_use_fwd();
    do_reset();
    issue(5'd5, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00);
    tick();
    issue(5'd6, 1'b1, 1'b0, 5'd0, 5'd5, 2'b01);
    cmp++; if (stall !== 1'b1) begin err++; $display("FAIL lu_stall0 got %0b want 1", stall); end
    cmp++; if (fwd_sel !== 4'b0000) begin err++; $display("FAIL lu_fwd_sel0 got %b want 0000", fwd_sel); end
    tick();
    cmp++; if (stall !== 1'b0) begin err++; $display("FAIL lu_stall1 got %0b want 0", stall); end
    cmp++; if (fwd_sel !== 4'b0010) begin err++; $display("FAIL lu_fwd_sel1 got %b want 0010", fwd_sel); end
    cmp++; if (fwd_data !== 64'h000000B1_000000A1) begin err++; $display("FAIL lu_fwd_data got %h want 000000b1000000a1", fwd_data); end
    cmp++; if (stall_count !== 16'd1) begin err++; $display("FAIL lu_stall_count got %0d want 1", stall_count); end
    cmp++; if (stage_valid !== 3'b010) begin err++; $display("FAIL lu_stage_valid got %b want 010", stage_valid); end
  endtask

  task automatic test_load_use_nofwd();
    do_reset();
    enable_forward = 1'b0;
    issue(5'd5, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00);
    tick();
    issue(5'd6, 1'b1, 1'b0, 5'd0, 5'd5, 2'b01);
    cmp++; if (stall !== 1'b1) begin err++; $display("FAIL nf_stall0 got %0b want 1", stall); end
    cmp++; if (fwd_sel !== 4'b0000) begin err++; $display("FAIL nf_fwd_sel0 got %b want 0000", fwd_sel); end
    tick();
    cmp++; if (stall !== 1'b1) begin err++; $display("FAIL nf_stall1 got %0b want 1", stall); end
    cmp++; if (fwd_sel !== 4'b0000) begin err++; $display("FAIL nf_fwd_sel1 got %b want 0000", fwd_sel); end
    tick();
    cmp++; if (stall !== 1'b0) begin err++; $display("FAIL nf_stall2 got %0b want 0", stall); end
    cmp++; if (fwd_sel !== 4'b0000) begin err++; $display("FAIL nf_fwd_sel2 got %b want 0000", fwd_sel); end
    cmp++; if (fwd_data !== 64'h000000B1_000000B0) begin err++; $display("FAIL nf_fwd_data got %h want 000000b1000000b0", fwd_data); end
    cmp++; if (stall_count !== 16'd2) begin err++; $display("FAIL nf_stall_count got %0d want 2", stall_count); end
    enable_forward = 1'b1;
    #1;
    cmp++; if (fwd_sel !== 4'b0011) begin err++; $display("FAIL nf_fwd_toggle got %b want 0011", fwd_sel); end
  endtask

  task automatic test_priority_r0();
    do_reset();
    issue(5'd7, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00);
    tick();
    issue(5'd7, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00);
    tick();
    issue(5'd8, 1'b1, 1'b0, 5'd0, 5'd7, 2'b01);
    cmp++; if (fwd_sel !== 4'b0001) begin err++; $display("FAIL pri_fwd_sel got %b want 0001", fwd_sel); end
    cmp++; if (fwd_data !== 64'h000000B1_000000A0) begin err++; $display("FAIL pri_fwd_data got %h want 000000b1000000a0", fwd_data); end
    issue(5'd7, 1'b1, 1'b0, 5'd7, 5'd0, 2'b10);
    cmp++; if (fwd_sel !== 4'b0100) begin err++; $display("FAIL pri_src1_sel got %b want 0100", fwd_sel); end
    issue(5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00);
    tick();
    issue(5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 2'b11);
    cmp++; if (stage_valid !== 3'b110) begin err++; $display("FAIL r0_stage_valid got %b want 110", stage_valid); end
    cmp++; if (stall !== 1'b0) begin err++; $display("FAIL r0_stall got %0b want 0", stall); end
    cmp++; if (fwd_sel !== 4'b0000) begin err++; $display("FAIL r0_fwd_sel got %b want 0000", fwd_sel); end
  endtask

  task automatic test_flush();
    do_reset();
    issue(5'd5, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00);
    tick();
    issue(5'd6, 1'b1, 1'b0, 5'd0, 5'd5, 2'b01);
    flush = 1'b1;
    #1;
    cmp++; if (stall !== 1'b0) begin err++; $display("FAIL fl_stall got %0b want 0", stall); end
    tick();
    flush = 1'b0;
    cmp++; if (stage_valid !== 3'b010) begin err++; $display("FAIL fl_stage_valid got %b want 010", stage_valid); end
    cmp++; if (stall_count !== 16'd0) begin err++; $display("FAIL fl_stall_count got %0d want 0", stall_count); end
  endtask

  task automatic test_async_reset_sat();
    do_reset();
    issue(5'd5, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00);
    tick();
    issue(5'd6, 1'b1, 1'b0, 5'd0, 5'd5, 2'b01);
    cmp++; if (stall !== 1'b1) begin err++; $display("FAIL ar_stall_pre got %0b want 1", stall); end
    reset = 1'b0;
    #1;
    cmp++; if (stall !== 1'b0) begin err++; $display("FAIL ar_stall got %0b want 0", stall); end
    cmp++; if (stage_valid !== 3'b000) begin err++; $display("FAIL ar_stage_valid got %b want 000", stage_valid); end
    reset = 1'b1;
    #1;
    for (int n = 0; n < 5; n++) begin
      issue(5'd5, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00);
      tick();
      issue(5'd6, 1'b1, 1'b0, 5'd0, 5'd5, 2'b01);
      tick();
    end
    cmp++; if (stall_count !== 16'd5) begin err++; $display("FAIL sat_count16 got %0d want 5", stall_count); end
    cmp++; if (stall_count2 !== 2'd3) begin err++; $display("FAIL sat_count2 got %0d want 3", stall_count2); end
  endtask

  initial begin
    reset = 1'b0;
    enable_forward = 1'b1;
    stage_data = {32'hA2, 32'hA1, 32'hA0};
    rf_data = {32'hB1, 32'hB0};
    issue(5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00);
    test_reset();
    test_alu_forward();
    test_load_use_fwd();
    test_load_use_nofwd();
    test_priority_r0();
    test_flush();
    test_async_reset_sat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
